// File: rtl/draw_move_hints_pkg.sv
// Shared chess board geometry and overlay colours, plus the pixel blend helper.
// mouse_position and chess_board read the same constants so the board is defined once.
package draw_move_hints_pkg;

   localparam int BOARD_X0 = 256;
   localparam int BOARD_Y0 = 128;
   localparam int SQ_LOG2  = 6;

   localparam logic [11:0] HINT_RGB = 12'h0F0;
   localparam logic [11:0] SEL_RGB  = 12'hFF0;

   typedef logic [5:0] square_idx_t;

   // 50/50 mix per 4-bit channel; both halves are at most 7, so the sum never overflows
   function automatic logic [11:0] blend_rgb(input logic [11:0] pix, input logic [11:0] tint);
      blend_rgb = {{1'b0, pix[11:9]} + {1'b0, tint[11:9]},
                   {1'b0, pix[7:5]}  + {1'b0, tint[7:5]},
                   {1'b0, pix[3:1]}  + {1'b0, tint[3:1]}};
   endfunction

endpackage

// File: rtl/draw_move_hints_if.sv
// VGA pixel stream passed between drawing stages.
interface vga_if;

   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_move_hints_latch.sv
// Captures move/selection data once per frame at the vblnk rising edge so the
// overlay cannot tear, and runs the frame counter that drives hint blinking.
module move_hint_latch
   import draw_move_hints_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic [63:0] possible_moves,
   input  square_idx_t sel_pos,
   input  logic        sel_valid,
   input  logic        hint_en,
   output logic [63:0] moves_l,
   output square_idx_t sel_pos_l,
   output logic        sel_valid_l,
   output logic        hint_en_l,
   output logic        blink_phase
);

   localparam int            CW   = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] LAST = CW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

   logic          vblnk_prev;
   logic          vblnk_rise;
   logic [CW-1:0] frame_cnt;

   assign vblnk_rise = vblnk && !vblnk_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_prev  <= 1'b0;
         moves_l     <= '0;
         sel_pos_l   <= '0;
         sel_valid_l <= 1'b0;
         hint_en_l   <= 1'b0;
      end else begin
         vblnk_prev <= vblnk;
         if (vblnk_rise) begin
            moves_l     <= possible_moves;
            sel_pos_l   <= sel_pos;
            sel_valid_l <= sel_valid;
            hint_en_l   <= hint_en;
         end
      end
   end

   // With BLINK_FRAMES of zero the counter still runs but the phase never leaves 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (vblnk_rise) begin
         if ((BLINK_FRAMES != 0) && (frame_cnt == LAST)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/draw_move_hints.sv
// VGA stage that blends a highlight over legal-move squares and borders the held
// piece's square; two register stages, sync/blank/counters only delayed.
module draw_move_hints
   import draw_move_hints_pkg::*;
#(
   parameter int BORDER_W     = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.slave        vga_in,
   vga_if.master       vga_out,
   input  logic [63:0] possible_moves,
   input  square_idx_t sel_pos,
   input  logic        sel_valid,
   input  logic        hint_en
);

   localparam int                 BOARD_LOG2 = SQ_LOG2 + 3;
   localparam logic [SQ_LOG2-1:0] BORDER_LO  = SQ_LOG2'(BORDER_W);
   localparam logic [SQ_LOG2-1:0] BORDER_HI  = SQ_LOG2'((1 << SQ_LOG2) - BORDER_W);

   logic [63:0] moves_l;
   square_idx_t sel_pos_l;
   logic        sel_valid_l;
   logic        hint_en_l;
   logic        blink_phase;

   move_hint_latch #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_latch (
      .clk            (clk),
      .rst            (rst),
      .vblnk          (vga_in.vblnk),
      .possible_moves (possible_moves),
      .sel_pos        (sel_pos),
      .sel_valid      (sel_valid),
      .hint_en        (hint_en),
      .moves_l        (moves_l),
      .sel_pos_l      (sel_pos_l),
      .sel_valid_l    (sel_valid_l),
      .hint_en_l      (hint_en_l),
      .blink_phase    (blink_phase)
   );

   // Two's-complement offsets: any high bit set means left of/above or beyond the board
   logic [11:0] dx;
   logic [11:0] dy;
   assign dx = {1'b0, vga_in.hcount} - 12'(BOARD_X0);
   assign dy = {1'b0, vga_in.vcount} - 12'(BOARD_Y0);

   logic               in_board_s1;
   logic [2:0]         row_s1;
   logic [2:0]         col_s1;
   logic [SQ_LOG2-1:0] ox_s1;
   logic [SQ_LOG2-1:0] oy_s1;
   logic [10:0]        hcount_s1;
   logic [10:0]        vcount_s1;
   logic               hsync_s1;
   logic               vsync_s1;
   logic               hblnk_s1;
   logic               vblnk_s1;
   logic [11:0]        rgb_s1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_board_s1 <= 1'b0;
         row_s1      <= '0;
         col_s1      <= '0;
         ox_s1       <= '0;
         oy_s1       <= '0;
         hcount_s1   <= '0;
         vcount_s1   <= '0;
         hsync_s1    <= 1'b0;
         vsync_s1    <= 1'b0;
         hblnk_s1    <= 1'b0;
         vblnk_s1    <= 1'b0;
         rgb_s1      <= '0;
      end else begin
         in_board_s1 <= (dx[11:BOARD_LOG2] == '0) && (dy[11:BOARD_LOG2] == '0);
         row_s1      <= dy[BOARD_LOG2-1:SQ_LOG2];
         col_s1      <= dx[BOARD_LOG2-1:SQ_LOG2];
         ox_s1       <= dx[SQ_LOG2-1:0];
         oy_s1       <= dy[SQ_LOG2-1:0];
         hcount_s1   <= vga_in.hcount;
         vcount_s1   <= vga_in.vcount;
         hsync_s1    <= vga_in.hsync;
         vsync_s1    <= vga_in.vsync;
         hblnk_s1    <= vga_in.hblnk;
         vblnk_s1    <= vga_in.vblnk;
         rgb_s1      <= vga_in.rgb;
      end
   end

   square_idx_t square_s1;
   logic        on_border;
   logic [11:0] rgb_next;

   // Border beats hint, so a held piece on a legal square shows a frame around a blended interior
   always_comb begin
      square_s1 = {row_s1, col_s1};
      on_border = (ox_s1 < BORDER_LO) || (ox_s1 >= BORDER_HI) ||
                  (oy_s1 < BORDER_LO) || (oy_s1 >= BORDER_HI);
      rgb_next  = rgb_s1;
      if (hblnk_s1 || vblnk_s1) begin
         rgb_next = 12'h000;
      end else if (!in_board_s1) begin
         rgb_next = rgb_s1;
      end else if (sel_valid_l && (square_s1 == sel_pos_l) && on_border) begin
         rgb_next = SEL_RGB;
      end else if (hint_en_l && blink_phase && moves_l[square_s1]) begin
         rgb_next = blend_rgb(rgb_s1, HINT_RGB);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vga_out.hcount <= '0;
         vga_out.vcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vga_out.hcount <= hcount_s1;
         vga_out.vcount <= vcount_s1;
         vga_out.hsync  <= hsync_s1;
         vga_out.vsync  <= vsync_s1;
         vga_out.hblnk  <= hblnk_s1;
         vga_out.vblnk  <= vblnk_s1;
         vga_out.rgb    <= rgb_next;
      end
   end

endmodule
